// File: rtl/key_event_if.sv
// Button-event bus: debounced button level in, event strobes and status out.
interface key_event_if;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] press_count;

    // Button source and event consumer side
    modport master (
        output pressed,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );

    // Event generator side
    modport slave (
        input  pressed,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );
endinterface

// File: rtl/key_event.sv
// Button event generator: press/release strobes, long-press detection and
// auto-repeat while held. A button still down at reset is ignored until it
// has been released once (LOCKOUT). All outputs are registered.
module key_event #(
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic        clk,
    input  logic        rst,
    key_event_if.slave  kif
);
    typedef enum logic [1:0] {LOCKOUT, IDLE, PRESS, LONG} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;

    // Next state, hold counter and strobes; release wins over any expiry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            LOCKOUT: begin
                cnt_d = '0;
                if (!kif.pressed) state_d = IDLE;
            end
            IDLE: begin
                cnt_d = '0;
                if (kif.pressed) begin
                    state_d = PRESS;
                    press_d = 1'b1;
                    count_d = count_q + 8'd1;
                end
            end
            PRESS: begin
                if (!kif.pressed) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (!kif.pressed) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOCKOUT;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESS) || (state_d == LONG);
    end

    // State and output registers; reset parks in LOCKOUT with everything cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOCKOUT;
            cnt_q   <= '0;
            count_q <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
        end
    end

    assign kif.press_pulse   = press_q;
    assign kif.release_pulse = rel_q;
    assign kif.long_pulse    = long_q;
    assign kif.repeat_pulse  = rep_q;
    assign kif.held          = held_q;
    assign kif.press_count   = count_q;
endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_key_event;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    key_event_if kif();

    key_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // out = {press, release, long, repeat, held}
    typedef struct {
        logic       r;
        logic       p;
        logic [4:0] out;
        logic [7:0] cnt;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic p, input logic [4:0] out,
                       input logic [7:0] cnt, input string tag);
        vec_t v;
        v.r = r; v.p = p; v.out = out; v.cnt = cnt; v.tag = tag;
        vecs.push_back(v);
    endtask

    function automatic logic [4:0] outs();
        return {kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.repeat_pulse, kif.held};
    endfunction

    task automatic chk(input string tag, input logic [4:0] exp_o, input logic [7:0] exp_c);
        checks++;
        if (outs() !== exp_o || kif.press_count !== exp_c) begin
            failures++;
            $display("FAIL %s: got {prs,rel,lng,rep,held}=%b count=%0d, want %b count=%0d",
                     tag, outs(), kif.press_count, exp_o, exp_c);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge
    task automatic step(input logic r, input logic p);
        @(negedge clk);
        rst = r;
        kif.pressed = p;
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] PRS  = 5'b10001;
    localparam logic [4:0] REL  = 5'b01000;
    localparam logic [4:0] LNG  = 5'b00101;
    localparam logic [4:0] REP  = 5'b00011;
    localparam logic [4:0] HLD  = 5'b00001;

    initial begin
        logic [7:0] cexp;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        kif.pressed = 1'b0;

        // Short press
        add(1, 0, NONE, 0, "reset");
        add(1, 0, NONE, 0, "reset2");
        add(0, 0, NONE, 0, "lockout_exit");
        add(0, 1, PRS,  1, "short_press");
        add(0, 1, HLD,  1, "short_hold1");
        add(0, 1, HLD,  1, "short_hold2");
        add(0, 0, REL,  1, "short_release");
        add(0, 0, NONE, 1, "short_idle");
        // Long press with auto-repeat
        add(1, 0, NONE, 0, "reset_b");
        add(0, 0, NONE, 0, "lockout_exit_b");
        add(0, 1, PRS,  1, "long_press");
        for (int i = 1; i <= 7; i++) add(0, 1, HLD, 1, $sformatf("long_hold%0d", i));
        add(0, 1, LNG,  1, "long_pulse");
        for (int i = 9; i <= 11; i++) add(0, 1, HLD, 1, $sformatf("long_hold%0d", i));
        add(0, 1, REP,  1, "repeat1");
        for (int i = 13; i <= 15; i++) add(0, 1, HLD, 1, $sformatf("long_hold%0d", i));
        add(0, 1, REP,  1, "repeat2");
        for (int i = 17; i <= 19; i++) add(0, 1, HLD, 1, $sformatf("long_hold%0d", i));
        add(0, 0, REL,  1, "long_release");
        add(0, 0, NONE, 1, "long_idle");
        // Release coincides with long expiry, then immediate re-press
        add(1, 0, NONE, 0, "reset_c");
        add(0, 0, NONE, 0, "lockout_exit_c");
        add(0, 1, PRS,  1, "edge_press");
        for (int i = 1; i <= 7; i++) add(0, 1, HLD, 1, $sformatf("edge_hold%0d", i));
        add(0, 0, REL,  1, "edge_release_only");
        add(0, 1, PRS,  2, "repress_next_cycle");
        add(0, 0, REL,  2, "repress_release");
        // Release on a repeat expiry: release only, no repeat
        add(0, 0, NONE, 2, "rp_idle");
        add(0, 1, PRS,  3, "rp_press");
        for (int i = 1; i <= 7; i++) add(0, 1, HLD, 3, $sformatf("rp_hold%0d", i));
        add(0, 1, LNG,  3, "rp_long");
        for (int i = 9; i <= 11; i++) add(0, 1, HLD, 3, $sformatf("rp_hold%0d", i));
        add(0, 0, REL,  3, "rp_release_only");
        // Button held through reset is locked out until released
        add(1, 1, NONE, 0, "held_in_reset");
        add(0, 1, NONE, 0, "lockout_held1");
        add(0, 1, NONE, 0, "lockout_held2");
        add(0, 0, NONE, 0, "lockout_release");
        add(0, 1, PRS,  1, "after_lockout_press");
        add(0, 0, REL,  1, "after_lockout_release");

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].p);
            chk(vecs[i].tag, vecs[i].out, vecs[i].cnt);
        end

        // 257 presses with one-cycle gaps: counter wraps through zero to 1
        step(1, 0);
        step(0, 0);
        cexp = 8'd0;
        for (int i = 0; i < 257; i++) begin
            step(0, 1);
            cexp = cexp + 8'd1;
            chk($sformatf("wrap_press%0d", i), PRS, cexp);
            step(0, 0);
            chk($sformatf("wrap_release%0d", i), REL, cexp);
        end
        chk("wrap_final", REL, 8'd1);

        // Asynchronous reset in the middle of a hold
        step(0, 1);
        chk("mid_press", PRS, 8'd2);
        step(0, 1);
        chk("mid_hold", HLD, 8'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", NONE, 8'd0);
        step(1, 1);
        chk("reset_held", NONE, 8'd0);
        step(0, 0);
        chk("no_release_after_reset", NONE, 8'd0);
        step(0, 0);
        chk("idle_after_reset", NONE, 8'd0);
        step(0, 1);
        chk("press_after_reset", PRS, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 SHALL provide parameter LONG_CYCLES, default 25000000, meaning clock cycles held before a long-press event (min 2).
REQ-002 SHALL provide parameter REPEAT_CYCLES, default 5000000, meaning clock cycles between auto-repeat events once long-press is reached (min 2).
REQ-003 SHALL provide parameter CNT_W, default 25, meaning hold-counter width; the integrator guarantees 2^CNT_W > max(LONG_CYCLES, REPEAT_CYCLES).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pressed  input  1  debounced button level, 1 = pressed, already synchronous to clk.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on release of an accepted press.
REQ-009 SHALL have port long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES while in long-hold.
REQ-011 SHALL have port held  output  1  level, 1 while an accepted press is in progress.
REQ-012 SHALL have port press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-013 SHALL implement FSM states LOCKOUT, IDLE, PRESS, LONG; all outputs registered.
REQ-014 LOCKOUT: SHALL stay while pressed=1; pressed=0 -> IDLE; no strobes generated.
REQ-015 IDLE with pressed=1 -> PRESS; press_pulse=1 next cycle; hold counter cleared to 0; press_count incremented.
REQ-016 PRESS: hold counter SHALL increment each cycle; when counter = LONG_CYCLES-1 -> LONG, long_pulse=1 next cycle, counter cleared.
REQ-017 LONG: counter SHALL increment each cycle; when counter = REPEAT_CYCLES-1, repeat_pulse=1 next cycle, counter cleared, state stays LONG.
REQ-018 PRESS or LONG with pressed=0 -> IDLE; release_pulse=1 next cycle; counter cleared.
REQ-019 Release SHALL take priority over long/repeat expiry in the same cycle: only release_pulse fires.
REQ-020 Each strobe SHALL be high for exactly one cycle; at most one strobe per cycle.
REQ-021 held SHALL be 1 exactly in cycles following an edge at which the next state is PRESS or LONG.
REQ-022 press_count SHALL wrap 255 -> 0 with no saturation or flag.
REQ-023 press_pulse SHALL lead long_pulse by exactly LONG_CYCLES cycles; consecutive repeat_pulse SHALL be REPEAT_CYCLES cycles apart; first repeat_pulse SHALL follow long_pulse by REPEAT_CYCLES cycles.
REQ-024 A release followed by pressed=1 on the very next cycle SHALL be accepted as a new press (IDLE dwell of one cycle).

Reset
REQ-025 rst=1 SHALL immediately force state LOCKOUT, counter 0, press_count 0, all strobes 0, held 0, independent of clk.
REQ-026 Reset during a press SHALL generate no release_pulse; a button still held at reset deassertion SHALL not be counted until released and pressed again.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-027 Reset with pressed=0, release rst, hold pressed=1 for 3 cycles then 0 -> one press_pulse, one release_pulse, no long_pulse, press_count=1, held high 3 cycles.
REQ-028 Hold pressed=1 for 20 cycles -> press_pulse; long_pulse 8 cycles later; repeat_pulse 4, 8 cycles after long_pulse; release_pulse after drop; press_count=1.
REQ-029 Hold pressed=1 for exactly 8 cycles (release coincides with long expiry) -> release_pulse only, no long_pulse.
REQ-030 pressed=1 through rst assertion and deassertion, release, press again -> no strobe until second press; press_count=1.
REQ-031 Apply 257 one-cycle-gap presses -> press_count=1 after wrap; assert rst mid-hold -> all outputs 0 asynchronously, no release_pulse.
